// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - multi-channel serial DAC transmitter with per-channel frame sync
module dac_serial_tx #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*DATA_W-1:0]   sample_data,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic                         sclk,
    output logic                         sync_n,
    output logic                         sdata,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // gap is counted in sclk half-periods, so it needs room for 2*GAP steps
    localparam int GAP_W   = $clog2(2 * GAP);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(2 * GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state;
    logic [FRAME_W-1:0]   shadow;
    logic [CH_W-1:0]      ch_idx;
    logic [BIT_W-1:0]     bit_idx;
    logic [DIV_W-1:0]     div_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    // Serial position idx of channel ch, honouring the shift order
    function automatic logic pick_bit(input logic [FRAME_W-1:0] frame,
                                      input int unsigned ch,
                                      input int unsigned idx);
        int unsigned pos;
        pos = (MSB_FIRST != 0) ? (int'(DATA_W) - 1 - idx) : idx;
        return |((frame >> (ch * int'(DATA_W) + pos)) & FRAME_W'(1));
    endfunction

    assign sample_ready = (state == S_IDLE);

    // Frame sequencer: accept, shift each channel on the divided clock, then gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shadow     <= '0;
            ch_idx     <= '0;
            bit_idx    <= '0;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            sclk       <= 1'b1;
            sync_n     <= 1'b1;
            sdata      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_valid) begin
                        shadow  <= sample_data;
                        state   <= S_SHIFT;
                        ch_idx  <= '0;
                        bit_idx <= '0;
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        sync_n  <= 1'b0;
                        sdata   <= pick_bit(sample_data, 0, 0);
                        busy    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // mid-bit: falling edge where the DAC samples
                            sclk <= 1'b0;
                        end else begin
                            sclk <= 1'b1;
                            if (bit_idx == BIT_LAST) begin
                                state   <= S_GAP;
                                sync_n  <= 1'b1;
                                sdata   <= 1'b0;
                                gap_cnt <= '0;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                sdata   <= pick_bit(shadow, 32'(ch_idx), 32'(bit_idx) + 1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (gap_cnt != GAP_LAST) begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end else if (ch_idx == CH_LAST) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            ch_idx  <= ch_idx + 1'b1;
                            bit_idx <= '0;
                            state   <= S_SHIFT;
                            sync_n  <= 1'b0;
                            sdata   <= pick_bit(shadow, 32'(ch_idx) + 1, 0);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - directed bench for dac_serial_tx in three configurations
module tb_dac_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: a value read at a negedge is the index of the preceding posedge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic        ra, va, rdy_a, sclk_a, sync_a, sd_a, busy_a, fd_a;
    logic [31:0] da;
    // Instance B: LSB first, one channel
    logic        rb, vb, rdy_b, sclk_b, sync_b, sd_b, busy_b, fd_b;
    logic [15:0] db;
    // Instance C: fast sclk, long gap, 4 x 8-bit channels
    logic        rc, vc, rdy_c, sclk_c, sync_c, sd_c, busy_c, fd_c;
    logic [31:0] dc;

    dac_serial_tx u_a (
        .clk(clk), .reset(ra), .sample_data(da), .sample_valid(va), .sample_ready(rdy_a),
        .sclk(sclk_a), .sync_n(sync_a), .sdata(sd_a), .busy(busy_a), .frame_done(fd_a)
    );

    dac_serial_tx #(.DATA_W(16), .CHANNELS(1), .CLK_DIV(2), .MSB_FIRST(0), .GAP(1)) u_b (
        .clk(clk), .reset(rb), .sample_data(db), .sample_valid(vb), .sample_ready(rdy_b),
        .sclk(sclk_b), .sync_n(sync_b), .sdata(sd_b), .busy(busy_b), .frame_done(fd_b)
    );

    dac_serial_tx #(.DATA_W(8), .CHANNELS(4), .CLK_DIV(1), .MSB_FIRST(1), .GAP(3)) u_c (
        .clk(clk), .reset(rc), .sample_data(dc), .sample_valid(vc), .sample_ready(rdy_c),
        .sclk(sclk_c), .sync_n(sync_c), .sdata(sd_c), .busy(busy_c), .frame_done(fd_c)
    );

    // DAC-side monitors: capture sdata on each sclk fall, log sync edges and frame_done
    logic [63:0] bits_a = '0, bits_b = '0, bits_c = '0;
    int nb_a = 0, nb_b = 0, nb_c = 0;
    int sf_a[$], sr_a[$], fdq_a[$], sf_c[$], sr_c[$];
    logic ps_a = 1'b1, pn_a = 1'b1, ps_b = 1'b1, ps_c = 1'b1, pn_c = 1'b1;

    always @(negedge clk) begin
        if (ps_a && !sclk_a) begin bits_a = {bits_a[62:0], sd_a}; nb_a++; end
        if (pn_a && !sync_a) sf_a.push_back(cyc);
        if (!pn_a && sync_a) sr_a.push_back(cyc);
        if (fd_a) fdq_a.push_back(cyc);
        ps_a = sclk_a;
        pn_a = sync_a;
    end

    always @(negedge clk) begin
        if (ps_b && !sclk_b) begin bits_b = {bits_b[62:0], sd_b}; nb_b++; end
        ps_b = sclk_b;
    end

    always @(negedge clk) begin
        if (ps_c && !sclk_c) begin bits_c = {bits_c[62:0], sd_c}; nb_c++; end
        if (pn_c && !sync_c) sf_c.push_back(cyc);
        if (!pn_c && sync_c) sr_c.push_back(cyc);
        ps_c = sclk_c;
        pn_c = sync_c;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Bounded wait for a frame_done pulse; at = -1 when the budget runs out
    task automatic wait_fd(input int which, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which == 0 && fd_a) || (which == 1 && fd_b) || (which == 2 && fd_c)) begin
                at = cyc;
                break;
            end
        end
    endtask

    int t, at, at2;
    logic [2:0] sc;

    initial begin
        // reset held with random inputs
        ra = 1'b0; rb = 1'b0; rc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            da = $urandom; db = 16'($urandom); dc = $urandom;
            va = 1'($urandom); vb = 1'($urandom); vc = 1'($urandom);
            @(negedge clk);
        end
        check("a_reset", {sclk_a, sync_a, sd_a, busy_a, fd_a, rdy_a}, 6'b110001);
        check("b_reset", {sclk_b, sync_b, sd_b, busy_b, fd_b, rdy_b}, 6'b110001);
        check("c_reset", {sclk_c, sync_c, sd_c, busy_c, fd_c, rdy_c}, 6'b110001);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        ra = 1'b1; rb = 1'b1; rc = 1'b1;
        repeat (3) @(negedge clk);

        // A: single frame, ch0=A5C3 ch1=0F01, MSB first
        bits_a = '0; nb_a = 0; sf_a.delete(); sr_a.delete();
        da = {16'h0F01, 16'hA5C3}; va = 1'b1; t = cyc + 1;
        @(negedge clk);
        va = 1'b0; da = $urandom;
        check("a_accept", {sync_a, sclk_a, sd_a, busy_a, rdy_a}, 5'b01110);
        wait_fd(0, at);
        check("a_fd_time", at, t + 136);
        check("a_fd_idle", {busy_a, rdy_a}, 2'b01);
        @(negedge clk);
        check("a_fd_pulse", fd_a, 1'b0);
        check("a_nbits", nb_a, 32);
        check("a_bits", bits_a[31:0], 32'hA5C30F01);
        check("a_sync_fall", {qat(sf_a, 0) - t, qat(sf_a, 1) - t}, {32'd0, 32'd68});
        check("a_sync_rise", {qat(sr_a, 0) - t, qat(sr_a, 1) - t}, {32'd64, 32'd132});

        // A: back-to-back, data changed while busy must be ignored
        repeat (2) @(negedge clk);
        bits_a = '0; nb_a = 0; sf_a.delete(); sr_a.delete();
        da = {16'hBEEF, 16'h1234}; va = 1'b1; t = cyc + 1;
        @(negedge clk);
        da = {16'h7FFE, 16'h8001};
        wait_fd(0, at);
        check("b2b_fd1_time", at, t + 136);
        @(negedge clk);
        va = 1'b0;
        check("b2b_second_accept", {sync_a, busy_a, rdy_a}, 3'b010);
        wait_fd(0, at2);
        check("b2b_fd2_time", at2, t + 137 + 136);
        check("b2b_nbits", nb_a, 64);
        check("b2b_bits", bits_a, 64'h1234BEEF80017FFE);
        check("b2b_sync_fall2", qat(sf_a, 2), t + 137);
        repeat (10) @(negedge clk);
        check("b2b_no_third", {busy_a, rdy_a}, 2'b01);

        // A: reset in channel 1, bit 7 (sclk low half of that bit)
        fdq_a.delete();
        da = {16'h5555, 16'hFFFF}; va = 1'b1; t = cyc + 1;
        @(negedge clk);
        va = 1'b0;
        while (cyc < t + 98) @(negedge clk);
        check("mid_active", {sclk_a, sync_a, sd_a, busy_a}, 4'b0011);
        ra = 1'b0;
        #1;
        check("mid_reset_idle", {sclk_a, sync_a, sd_a, busy_a, fd_a, rdy_a}, 6'b110001);
        repeat (2) @(negedge clk);
        ra = 1'b1;
        repeat (150) @(negedge clk);
        check("mid_no_fd", fdq_a.size(), 0);
        bits_a = '0; nb_a = 0;
        da = {16'h9001, 16'h3C5A}; va = 1'b1; t = cyc + 1;
        @(negedge clk);
        va = 1'b0;
        wait_fd(0, at);
        check("post_reset_fd", at, t + 136);
        check("post_reset_bits", {nb_a, bits_a[31:0]}, {32'd32, 32'h3C5A9001});

        // B: LSB first, single channel, 16'h0001
        bits_b = '0; nb_b = 0;
        db = 16'h0001; vb = 1'b1; t = cyc + 1;
        @(negedge clk);
        vb = 1'b0;
        check("b_first_bit", {sync_b, sd_b, busy_b}, 3'b011);
        wait_fd(1, at);
        check("b_fd_time", at, t + 68);
        check("b_bits", {nb_b, bits_b[15:0]}, {32'd16, 16'h8000});

        // C: CLK_DIV=1, GAP=3, 4 x 8-bit; input scrambled right after acceptance
        bits_c = '0; nb_c = 0; sf_c.delete(); sr_c.delete();
        dc = {8'h18, 8'h24, 8'h42, 8'h81}; vc = 1'b1; t = cyc + 1;
        @(negedge clk);
        vc = 1'b0; dc = 32'hFFFF_FFFF;
        sc[2] = sclk_c;
        @(negedge clk);
        sc[1] = sclk_c;
        @(negedge clk);
        sc[0] = sclk_c;
        check("c_sclk_period", sc, 3'b101);
        wait_fd(2, at);
        check("c_fd_time", at, t + 88);
        check("c_bits", {nb_c, bits_c[31:0]}, {32'd32, 32'h81422418});
        check("c_sync_fall", {qat(sf_c, 1) - t, qat(sf_c, 3) - t}, {32'd22, 32'd66});
        check("c_sync_rise", {qat(sr_c, 0) - t, qat(sr_c, 3) - t}, {32'd16, 32'd82});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
